// File: rtl/gol_pkg.sv
// gol_pkg: shared constants and types for the Game of Life generation controller.
//   CELLS  - number of cells in the cell RAM (scan/write counters run 0..CELLS-1)
//   ADDR_W - cell address width
//   GEN_W  - generation counter width
//   gol_state_t - sequencer state encoding
package gol_pkg;

  localparam int unsigned CELLS  = 300;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned GEN_W  = 16;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } gol_state_t;

endpackage

// File: rtl/gol_cell_rule.sv
// gol_cell_rule: combinational Conway Life rule for one cell.
// Ports:
//   cur_i   - current state of the cell
//   neigh_i - states of the eight neighbours (bit order irrelevant)
//   next_o  - state of the cell in the next generation
module gol_cell_rule (
  input  logic       cur_i,
  input  logic [7:0] neigh_i,
  output logic       next_o
);

  logic [3:0] n_s;

  // Count live neighbours.
  always_comb begin
    n_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n_s = n_s + {3'd0, neigh_i[i]};
    end
  end

  // Birth on exactly three, survival on two or three.
  assign next_o = (n_s == 4'd3) | (cur_i & (n_s == 4'd2));

endmodule

// File: rtl/gol_gen_ctrl.sv
// gol_gen_ctrl: generation sequencer and cell-RAM port arbiter.
// A step request runs a scan pass (compute next state of every cell into a
// shadow buffer) followed by a write pass (commit the shadow buffer). Between
// generations, edit writes from the user logic are granted combinationally.
// Optional feature macro: GOL_STABLE_DETECT_EN adds stable_o and skips the
// write pass when a scan finds no cell changing.
// Ports:
//   clk_50MHz_i, rst_i (sync, active-high)
//   step_i                          - one-cycle generation request
//   edit_we_i/edit_addr_i/edit_data_i, edit_ack_o - edit write handshake
//   ram_addr_o/ram_we_o/ram_data_o  - RAM port driven by this block
//   ram_data_i/ram_neigh_i          - RAM read data and neighbour vector
//   busy_o, done_o                  - status
//   gen_count_o, alive_count_o      - completed generations, live cell count
//   stable_o (feature only)         - last generation changed nothing
module gol_gen_ctrl
  import gol_pkg::*;
(
  input  logic              clk_50MHz_i,
  input  logic              rst_i,
  input  logic              step_i,
  input  logic              edit_we_i,
  input  logic [ADDR_W-1:0] edit_addr_i,
  input  logic              edit_data_i,
  output logic              edit_ack_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic              ram_data_o,
  input  logic              ram_data_i,
  input  logic [7:0]        ram_neigh_i,
  output logic              busy_o,
  output logic              done_o,
`ifdef GOL_STABLE_DETECT_EN
  output logic              stable_o,
`endif
  output logic [GEN_W-1:0]  gen_count_o,
  output logic [ADDR_W-1:0] alive_count_o
);

  gol_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [CELLS-1:0]  shadow_q, shadow_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic [ADDR_W-1:0] alive_q, alive_d;
  logic              changed_q, changed_d;
  logic              stable_q, stable_d;
  logic              next_s;

  gol_cell_rule u_rule (
    .cur_i   (ram_data_i),
    .neigh_i (ram_neigh_i),
    .next_o  (next_s)
  );

  // Sequencer next-state, RAM port mux and edit grant.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    shadow_d   = shadow_q;
    acc_d      = acc_q;
    gen_d      = gen_q;
    alive_d    = alive_q;
    changed_d  = changed_q;
    stable_d   = stable_q;
    ram_addr_o = '0;
    ram_we_o   = 1'b0;
    ram_data_o = 1'b0;
    edit_ack_o = 1'b0;
    done_o     = 1'b0;

    // A step that cannot start right now is remembered (at most one).
    if (step_i && ((state_q != ST_IDLE) || edit_we_i)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end

    case (state_q)
      ST_IDLE: begin
        if (edit_we_i) begin
          ram_addr_o = edit_addr_i;
          ram_data_o = edit_data_i;
          ram_we_o   = 1'b1;
          edit_ack_o = 1'b1;
        end else if (pend_q || step_i) begin
          state_d   = ST_SCAN;
          pend_d    = 1'b0;
          cnt_d     = '0;
          acc_d     = '0;
          changed_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        ram_addr_o       = cnt_q;
        shadow_d[cnt_q]  = next_s;
        acc_d            = acc_q + {{(ADDR_W-1){1'b0}}, next_s};
        changed_d        = changed_q | (next_s != ram_data_i);
        if (cnt_q == LAST_CELL) begin
          cnt_d = '0;
`ifdef GOL_STABLE_DETECT_EN
          if (changed_d) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_WRITE;
`endif
        end else begin
          cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WRITE: begin
        ram_addr_o = cnt_q;
        ram_we_o   = 1'b1;
        ram_data_o = shadow_q[cnt_q];
        if (cnt_q == LAST_CELL) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        done_o    = 1'b1;
        gen_d     = gen_q + {{(GEN_W-1){1'b0}}, 1'b1};
        alive_d   = acc_q;
        acc_d     = '0;
        stable_d  = ~changed_q;
        changed_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_50MHz_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      shadow_q  <= '0;
      acc_q     <= '0;
      gen_q     <= '0;
      alive_q   <= '0;
      changed_q <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      acc_q     <= acc_d;
      gen_q     <= gen_d;
      alive_q   <= alive_d;
      changed_q <= changed_d;
      stable_q  <= stable_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign gen_count_o   = gen_q;
  assign alive_count_o = alive_q;
`ifdef GOL_STABLE_DETECT_EN
  assign stable_o      = stable_q;
`else
  logic unused_s;
  assign unused_s = stable_q;
`endif

endmodule

// File: tb/tb_gol_gen_ctrl.sv
// tb_gol_gen_ctrl: self-checking bench for gol_gen_ctrl with a behavioural
// cell RAM (20 columns x 15 rows, addr = col*15 + row, dead outside the grid).
module tb_gol_gen_ctrl;

  localparam int NC = 300;

  logic       clk = 1'b0;
  logic       rst_i, step_i, edit_we_i, edit_data_i, edit_ack_o;
  logic [8:0] edit_addr_i, ram_addr_o;
  logic       ram_we_o, ram_data_o, ram_data_i, busy_o, done_o;
  logic [7:0] ram_neigh_i;
  logic [15:0] gen_count_o;
  logic [8:0] alive_count_o;
`ifdef GOL_STABLE_DETECT_EN
  logic       stable_o;
`endif

  logic [NC-1:0] mem, load_val;
  logic          load_en;
  int            checks = 0;
  int            failures = 0;
  int            exp_gen = 0;

  always #10 clk = ~clk;

  gol_gen_ctrl dut (
    .clk_50MHz_i  (clk),
    .rst_i        (rst_i),
    .step_i       (step_i),
    .edit_we_i    (edit_we_i),
    .edit_addr_i  (edit_addr_i),
    .edit_data_i  (edit_data_i),
    .edit_ack_o   (edit_ack_o),
    .ram_addr_o   (ram_addr_o),
    .ram_we_o     (ram_we_o),
    .ram_data_o   (ram_data_o),
    .ram_data_i   (ram_data_i),
    .ram_neigh_i  (ram_neigh_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
`ifdef GOL_STABLE_DETECT_EN
    .stable_o     (stable_o),
`endif
    .gen_count_o  (gen_count_o),
    .alive_count_o(alive_count_o)
  );

  function automatic logic cell_at(input logic [NC-1:0] m, input int x, input int y);
    if (x < 0 || x >= 20 || y < 0 || y >= 15) return 1'b0;
    return m[x*15 + y];
  endfunction

  function automatic logic read_bit(input logic [NC-1:0] m, input logic [8:0] a);
    if (int'(a) >= NC) return 1'b0;
    return m[int'(a)];
  endfunction

  function automatic logic [7:0] neigh_of(input logic [NC-1:0] m, input logic [8:0] a);
    logic [7:0] v;
    int k;
    v = 8'd0;
    k = 0;
    if (int'(a) < NC) begin
      for (int dx = -1; dx <= 1; dx++)
        for (int dy = -1; dy <= 1; dy++)
          if (dx != 0 || dy != 0) begin
            v[k] = cell_at(m, int'(a) / 15 + dx, int'(a) % 15 + dy);
            k++;
          end
    end
    return v;
  endfunction

  // Reference generation computed on the 2-D grid.
  function automatic logic [NC-1:0] life_next(input logic [NC-1:0] m);
    logic [NC-1:0] r;
    int n;
    for (int x = 0; x < 20; x++)
      for (int y = 0; y < 15; y++) begin
        n = 0;
        for (int dx = -1; dx <= 1; dx++)
          for (int dy = -1; dy <= 1; dy++)
            if ((dx != 0 || dy != 0) && cell_at(m, x + dx, y + dy)) n++;
        r[x*15 + y] = (n == 3) || (m[x*15 + y] && n == 2);
      end
    return r;
  endfunction

  function automatic int exp_lat(input logic [NC-1:0] cur, input logic [NC-1:0] nxt);
`ifdef GOL_STABLE_DETECT_EN
    if (cur == nxt) return NC + 1;
`endif
    return 2*NC + 1;
  endfunction

  function automatic logic [NC-1:0] rand_grid();
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = ($urandom_range(0, 99) < 30);
    return v;
  endfunction

  assign ram_data_i  = read_bit(mem, ram_addr_o);
  assign ram_neigh_i = neigh_of(mem, ram_addr_o);

  always @(posedge clk) begin
    if (load_en) mem <= load_val;
    else if (ram_we_o && int'(ram_addr_o) < NC) mem[ram_addr_o] <= ram_data_o;
  end

  task automatic load(input logic [NC-1:0] v);
    load_val = v;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Runs one generation; reports latency, write count and idle-while-busy cycles.
  task automatic run_gen(input bit do_step, output int lat, output int wes, output int berr);
    int cyc;
    lat = -1; wes = 0; berr = 0; cyc = 0;
    step_i = do_step;
    while (lat < 0 && cyc < 2000) begin
      @(negedge clk);
      step_i = 1'b0;
      cyc++;
      #1;
      if (ram_we_o) wes++;
      if (!busy_o) berr++;
      if (done_o) lat = cyc;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, ram_we_o, ram_data_o, edit_ack_o} !== 5'b0 || ram_addr_o !== 9'd0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b done=%b we=%b data=%b ack=%b addr=%0d want all 0",
               busy_o, done_o, ram_we_o, ram_data_o, edit_ack_o, ram_addr_o);
    end
    checks++;
    if (gen_count_o !== 16'd0 || alive_count_o !== 9'd0) begin
      failures++;
      $display("FAIL reset_counts got gen=%0d alive=%0d want 0 0", gen_count_o, alive_count_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    logic [NC-1:0] r, exp;
    int lat, wes, berr;
    r = rand_grid();
    load(r);
    step_i = 1'b1;
    repeat (100) begin
      @(negedge clk);
      step_i = 1'b0;
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || ram_we_o !== 1'b0 || gen_count_o !== 16'(exp_gen)) begin
      failures++;
      $display("FAIL midscan_reset got busy=%b we=%b gen=%0d want 0 0 %0d", busy_o, ram_we_o, gen_count_o, exp_gen);
    end
    checks++;
    if (mem !== r) begin
      failures++;
      $display("FAIL midscan_ram got %h want %h", mem, r);
    end
    exp = life_next(mem);
    run_gen(1'b1, lat, wes, berr);
    exp_gen++;
    checks++;
    if (lat != exp_lat(r, exp) || mem !== exp || gen_count_o !== 16'(exp_gen)) begin
      failures++;
      $display("FAIL after_reset_gen got lat=%0d gen=%0d want lat=%0d gen=%0d ram_ok=%b",
               lat, gen_count_o, exp_lat(r, exp), exp_gen, mem === exp);
    end
  endtask

  task automatic test_blinker();
    logic [NC-1:0] b, want;
    int lat, wes, berr;
    b = '0; b[32] = 1'b1; b[47] = 1'b1; b[62] = 1'b1;
    want = '0; want[46] = 1'b1; want[47] = 1'b1; want[48] = 1'b1;
    load(b);
    run_gen(1'b1, lat, wes, berr);
    exp_gen++;
    checks++;
    if (lat != 601) begin failures++; $display("FAIL blinker_latency got %0d want 601", lat); end
    checks++;
    if (wes != NC || berr != 0) begin
      failures++;
      $display("FAIL blinker_busy_we got writes=%0d idle_cycles=%0d want %0d 0", wes, berr, NC);
    end
    checks++;
    if (mem !== want) begin failures++; $display("FAIL blinker_ram1 got %h want %h", mem, want); end
    checks++;
    if (alive_count_o !== 9'd3 || gen_count_o !== 16'(exp_gen)) begin
      failures++;
      $display("FAIL blinker_counts got alive=%0d gen=%0d want 3 %0d", alive_count_o, gen_count_o, exp_gen);
    end
`ifdef GOL_STABLE_DETECT_EN
    checks++;
    if (stable_o !== 1'b0) begin failures++; $display("FAIL blinker_stable got %b want 0", stable_o); end
`endif
    run_gen(1'b1, lat, wes, berr);
    exp_gen++;
    checks++;
    if (mem !== b || lat != 601 || gen_count_o !== 16'(exp_gen)) begin
      failures++;
      $display("FAIL blinker_ram2 got lat=%0d gen=%0d ram_ok=%b want 601 %0d 1", lat, gen_count_o, mem === b, exp_gen);
    end
  endtask

  task automatic test_random();
    logic [NC-1:0] cur, exp;
    int lat, wes, berr;
    for (int t = 0; t < 4; t++) begin
      cur = rand_grid();
      load(cur);
      exp = life_next(cur);
      run_gen(1'b1, lat, wes, berr);
      exp_gen++;
      checks++;
      if (mem !== exp) begin failures++; $display("FAIL random_ram[%0d] got %h want %h", t, mem, exp); end
      checks++;
      if (alive_count_o !== 9'($countones(exp)) || gen_count_o !== 16'(exp_gen)) begin
        failures++;
        $display("FAIL random_counts[%0d] got alive=%0d gen=%0d want %0d %0d",
                 t, alive_count_o, gen_count_o, $countones(exp), exp_gen);
      end
      checks++;
      if (lat != exp_lat(cur, exp) || berr != 0) begin
        failures++;
        $display("FAIL random_latency[%0d] got %0d idle=%0d want %0d 0", t, lat, berr, exp_lat(cur, exp));
      end
    end
  endtask

  task automatic test_collision();
    logic [NC-1:0] v, exp;
    int lat, wes, berr;
    v = rand_grid();
    v[100] = 1'b0;
    load(v);
    edit_we_i = 1'b1; edit_addr_i = 9'd100; edit_data_i = 1'b1; step_i = 1'b1;
    #1;
    checks++;
    if (edit_ack_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 9'd100 || ram_data_o !== 1'b1) begin
      failures++;
      $display("FAIL collision_grant got ack=%b we=%b addr=%0d data=%b want 1 1 100 1",
               edit_ack_o, ram_we_o, ram_addr_o, ram_data_o);
    end
    @(negedge clk);
    edit_we_i = 1'b0; step_i = 1'b0;
    #1;
    checks++;
    if (mem[100] !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL collision_edit got ram100=%b busy=%b want 1 0", mem[100], busy_o);
    end
    v[100] = 1'b1;
    exp = life_next(v);
    run_gen(1'b0, lat, wes, berr);
    exp_gen++;
    checks++;
    if (lat != exp_lat(v, exp) || mem !== exp || gen_count_o !== 16'(exp_gen)) begin
      failures++;
      $display("FAIL collision_pending_step got lat=%0d gen=%0d ram_ok=%b want %0d %0d 1",
               lat, gen_count_o, mem === exp, exp_lat(v, exp), exp_gen);
    end
  endtask

  task automatic test_edit_during_write();
    logic [NC-1:0] cur, exp;
    logic d;
    int cyc, lat, ack_err;
    cur = rand_grid();
    load(cur);
    exp = life_next(cur);
    d = ~exp[5];
    cyc = 0; lat = -1; ack_err = 0;
    step_i = 1'b1;
    while (lat < 0 && cyc < 2000) begin
      @(negedge clk);
      step_i = 1'b0;
      cyc++;
      if (cyc == 400) begin
        edit_we_i = 1'b1; edit_addr_i = 9'd5; edit_data_i = d;
      end
      #1;
      if (edit_ack_o) ack_err++;
      if (done_o) lat = cyc;
    end
    exp_gen++;
    checks++;
    if (ack_err != 0 || lat != 601) begin
      failures++;
      $display("FAIL busy_edit_ack got early_acks=%0d lat=%0d want 0 601", ack_err, lat);
    end
    @(negedge clk);
    #1;
    checks++;
    if (edit_ack_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 9'd5 || ram_data_o !== d) begin
      failures++;
      $display("FAIL idle_edit_grant got ack=%b we=%b addr=%0d data=%b want 1 1 5 %b",
               edit_ack_o, ram_we_o, ram_addr_o, ram_data_o, d);
    end
    @(negedge clk);
    edit_we_i = 1'b0;
    #1;
    exp[5] = d;
    checks++;
    if (mem !== exp || gen_count_o !== 16'(exp_gen)) begin
      failures++;
      $display("FAIL edit_lands got gen=%0d ram_ok=%b want %0d 1", gen_count_o, mem === exp, exp_gen);
    end
  endtask

`ifdef GOL_STABLE_DETECT_EN
  task automatic test_stable();
    logic [NC-1:0] blk;
    int lat, wes, berr;
    blk = '0; blk[47] = 1'b1; blk[48] = 1'b1; blk[62] = 1'b1; blk[63] = 1'b1;
    load(blk);
    run_gen(1'b1, lat, wes, berr);
    exp_gen++;
    checks++;
    if (lat != 301 || wes != 0 || stable_o !== 1'b1 || mem !== blk || gen_count_o !== 16'(exp_gen)) begin
      failures++;
      $display("FAIL stable_block got lat=%0d writes=%0d stable=%b gen=%0d want 301 0 1 %0d",
               lat, wes, stable_o, gen_count_o, exp_gen);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; step_i = 1'b0; edit_we_i = 1'b0; edit_addr_i = 9'd0; edit_data_i = 1'b0;
    load_en = 1'b0; load_val = '0;
    test_reset();
    test_reset_mid_scan();
    test_blinker();
    test_random();
    test_collision();
    test_edit_during_write();
`ifdef GOL_STABLE_DETECT_EN
    test_stable();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
